// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings, word width and FSM state type for the multiply/divide unit
package mdu_pkg;
  localparam int WORD_WIDTH = 32;
  localparam int MDU_OP_W = 3;
  localparam logic [MDU_OP_W-1:0] MDU_OP_MULT  = 3'd0;
  localparam logic [MDU_OP_W-1:0] MDU_OP_MULTU = 3'd1;
  localparam logic [MDU_OP_W-1:0] MDU_OP_DIV   = 3'd2;
  localparam logic [MDU_OP_W-1:0] MDU_OP_DIVU  = 3'd3;
  localparam logic [MDU_OP_W-1:0] MDU_OP_MTHI  = 3'd4;
  localparam logic [MDU_OP_W-1:0] MDU_OP_MTLO  = 3'd5;
  typedef enum logic {S_IDLE, S_RUN} state_e;
  function automatic logic is_iter(input logic [MDU_OP_W-1:0] op);
    return op == MDU_OP_MULT || op == MDU_OP_MULTU || op == MDU_OP_DIV || op == MDU_OP_DIVU;
  endfunction
endpackage

// File: rtl/mdu_sign.sv
// mdu_sign: operand magnitudes before iteration and sign correction of the 2W-bit raw result
module mdu_sign #(
  parameter int W = 32
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           sgn,
  input  logic           div,
  input  logic           neg_q,
  input  logic           neg_r,
  input  logic [2*W-1:0] raw,
  output logic           sa,
  output logic           sb,
  output logic [W-1:0]   mag_a,
  output logic [W-1:0]   mag_b,
  output logic [2*W-1:0] fixed
);
  // magnitudes feed the unsigned core; divide fixes quotient and remainder separately, multiply negates all 2W bits
  always_comb begin
    sa = sgn & a[W-1];
    sb = sgn & b[W-1];
    mag_a = sa ? -a : a;
    mag_b = sb ? -b : b;
    fixed = div ? {neg_r ? -raw[2*W-1:W] : raw[2*W-1:W], neg_q ? -raw[W-1:0] : raw[W-1:0]}
                : (neg_q ? -raw : raw);
  end
endmodule

// File: rtl/mdu.sv
// mdu: iterative radix-2 multiply/divide unit with HI/LO registers, one step per clock
module mdu
  import mdu_pkg::*;
#(
  parameter int W = WORD_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [MDU_OP_W-1:0] op,
  input  logic [W-1:0]        a,
  input  logic [W-1:0]        b,
  input  logic                flush,
  output logic                busy,
  output logic                done,
  output logic [W-1:0]        hi,
  output logic [W-1:0]        lo
);
  localparam int CW = $clog2(W) + 1;
  state_e state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2*W-1:0] acc, acc_nxt, fixed;
  logic [W-1:0] d, mag_a, mag_b;
  logic [W:0] sum, trial;
  logic is_div, neg_q, neg_r, sa, sb, accept, op_div, last;
  assign accept = state == S_IDLE && start && !flush;
  assign op_div = op == MDU_OP_DIV || op == MDU_OP_DIVU;
  assign last = cnt == CW'(W - 1);
  mdu_sign #(.W(W)) u_sign (
    .a(a),
    .b(b),
    .sgn(op == MDU_OP_MULT || op == MDU_OP_DIV),
    .div(is_div),
    .neg_q(neg_q),
    .neg_r(neg_r),
    .raw(acc_nxt),
    .sa(sa),
    .sb(sb),
    .mag_a(mag_a),
    .mag_b(mag_b),
    .fixed(fixed)
  );
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= S_IDLE;
    else state <= state_nxt;
  // next state: enter RUN on an accepted iterative op, leave on flush or the final step
  always_comb
    state_nxt = state == S_IDLE ? (accept && is_iter(op) ? S_RUN : S_IDLE)
                                : (flush || last ? S_IDLE : S_RUN);
  // outputs decoded from state
  always_comb busy = state == S_RUN;
  // one step on the shared accumulator: shift-add for multiply, restoring subtract for divide
  always_comb begin
    sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, d} : '0);
    trial = acc[2*W-1:W-1] - {1'b0, d};
    acc_nxt = is_div ? (trial[W] ? {acc[2*W-2:0], 1'b0} : {trial[W-1:0], acc[W-2:0], 1'b1})
                     : {sum, acc[W-1:1]};
  end
  // operand capture, iteration, HI/LO writeback and the done pulse
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      acc <= '0;
      d <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      done <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      done <= state == S_RUN && last && !flush;
      if (accept && is_iter(op)) begin
        cnt <= '0;
        is_div <= op_div;
        neg_q <= (sa ^ sb) && !(op_div && b == '0);
        neg_r <= sa;
        d <= op_div ? mag_b : mag_a;
        acc <= {{W{1'b0}}, op_div ? mag_a : mag_b};
      end else if (state == S_RUN) begin
        cnt <= cnt + 1'b1;
        acc <= acc_nxt;
        if (last && !flush) {hi, lo} <= fixed;
      end
      if (accept && op == MDU_OP_MTHI) hi <= a;
      if (accept && op == MDU_OP_MTLO) lo <= a;
    end
endmodule
